sort_frame_loader: RTL and testbench

Upstream feeder for the min/max sort comparator. It accepts a stream of `DATA_WIDTH` words over a valid/ready handshake and packs `NUM_INPUTS` of them into the comparator's combined `DIN` vector. It then sequences the comparator's active-low reset to launch one sort, captures the single-cycle `DOUT`/`SORT_DONE` result, and presents it downstream on a valid/ready result port.

---
 rtl/sort_pkg.sv | 22 ++
 rtl/sort_frame_packer.sv | 59 +++++
 rtl/sort_frame_loader.sv | 135 +++++++++++++
 tb/tb_sort_frame_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and defaults for the min/max sort comparator and its frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Ports: none; provides sfl_state_t, default DATA_WIDTH/NUM_INPUTS and an index-width helper.
package sort_pkg;

  localparam int SORT_DATA_WIDTH = 16;
  localparam int SORT_NUM_INPUTS = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } sfl_state_t;

  // Width of a lane index; a single-lane frame still gets one bit so vectors stay legal.
  function automatic int sort_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_frame_packer.sv
// Packs accepted words lane by lane into the comparator DIN vector, tracking the lane index.
// Latency: a word written at an edge appears on o_din right after that edge.
// Backpressure: none of its own; i_wr is the upstream handshake decided by the top level.
// Ports: i_clk, i_rst_n (sync, active-low), i_wr (word accepted), i_dat (word),
//        o_first (next word is lane 0), o_last (next word is the final lane), o_din (packed frame).
module sort_frame_packer
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = SORT_DATA_WIDTH,
  parameter int NUM_INPUTS = SORT_NUM_INPUTS
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_wr,
  input  logic [DATA_WIDTH-1:0]            i_dat,
  output logic                             o_first,
  output logic                             o_last,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] o_din
);

  localparam int IW = sort_idx_width(NUM_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);

  logic [IW-1:0]                    r_idx;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] r_din;
  logic [NUM_INPUTS-1:0]            w_lane_we;

  // One-hot lane write enable from the current index.
  always_comb begin
    w_lane_we = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_lane_we[k] = i_wr && (r_idx == IW'(k));
    end
  end

  // The index wraps to 0 on the final lane, so a completed (or abandoned)
  // frame always leaves the packer ready for lane 0 without an extra clear.
  // Lanes are never cleared between frames; each is overwritten in turn.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_din <= '0;
    end else begin
      if (i_wr) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (w_lane_we[k]) begin
          r_din[k*DATA_WIDTH +: DATA_WIDTH] <= i_dat;
        end
      end
    end
  end

  assign o_first = (r_idx == '0);
  assign o_last  = (r_idx == LAST_IDX);
  assign o_din   = r_din;

endmodule

// File: rtl/sort_frame_loader.sv
// Feeds one frame of NUM_INPUTS words to the sort comparator, launches it and returns the min/max.
// Latency: result valid 3 cycles after the last input handshake; frame period >= NUM_INPUTS+4.
// Backpressure: IN_READY only in FILL; a pending result holds until RES_READY, stalling input.
// Ports: CLK, RST_N (sync, active-low); IN_VALID/IN_READY/IN_DATA/MODE_IN word stream;
//        CMP_RST_N/CMP_MODE/CMP_DIN/CMP_DOUT/CMP_DONE comparator side;
//        RES_VALID/RES_READY/RES_DATA/RES_MODE result stream; TIMEOUT_ERR abandon pulse.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH     = SORT_DATA_WIDTH,
  parameter int NUM_INPUTS     = SORT_NUM_INPUTS,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic [DATA_WIDTH-1:0]            IN_DATA,
  input  logic                             MODE_IN,
  output logic                             CMP_RST_N,
  output logic                             CMP_MODE,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] CMP_DIN,
  input  logic [DATA_WIDTH-1:0]            CMP_DOUT,
  input  logic                             CMP_DONE,
  output logic                             RES_VALID,
  input  logic                             RES_READY,
  output logic [DATA_WIDTH-1:0]            RES_DATA,
  output logic                             RES_MODE,
  output logic                             TIMEOUT_ERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter is cleared on RUN entry and checked before incrementing, so
  // hitting LAST at an edge means TIMEOUT_CYCLES RUN cycles have elapsed.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  sfl_state_t            r_state;
  logic                  r_in_ready;
  logic                  r_cmp_rst_n;
  logic                  r_mode;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_timeout_err;
  logic [CW-1:0]         r_cnt;

  logic                  w_accept;
  logic                  w_first;
  logic                  w_last;

  // r_in_ready is only ever high in FILL, so it alone qualifies the handshake.
  assign w_accept = IN_VALID && r_in_ready;

  sort_frame_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_packer (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_wr    (w_accept),
    .i_dat   (IN_DATA),
    .o_first (w_first),
    .o_last  (w_last),
    .o_din   (CMP_DIN)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= FILL;
      r_in_ready    <= 1'b0;
      r_cmp_rst_n   <= 1'b0;
      r_mode        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_first) begin
              r_mode <= MODE_IN;
            end
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_state    <= LOAD;
            end
          end
        end
        LOAD: begin
          // Comparator has loaded DIN while held in reset; release it now.
          r_cmp_rst_n <= 1'b1;
          r_cnt       <= '0;
          r_state     <= RUN;
        end
        RUN: begin
          // A result arriving on the last allowed cycle still wins over the timeout.
          if (CMP_DONE) begin
            r_res_data  <= CMP_DOUT;
            r_res_valid <= 1'b1;
            r_cmp_rst_n <= 1'b0;
            r_state     <= HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b1;
            r_cmp_rst_n   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_state       <= FILL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign IN_READY    = r_in_ready;
  assign CMP_RST_N   = r_cmp_rst_n;
  assign CMP_MODE    = r_mode;
  assign RES_VALID   = r_res_valid;
  assign RES_DATA    = r_res_data;
  assign RES_MODE    = r_mode;
  assign TIMEOUT_ERR = r_timeout_err;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Bench for sort_frame_loader with a behavioural comparator attached.
// Latency: n/a.
// Backpressure: RES_READY is held, released or randomised per test.
module tb_sort_frame_loader;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int TO = 6;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            IN_VALID;
  logic            IN_READY;
  logic [DW-1:0]   IN_DATA;
  logic            MODE_IN;
  logic            CMP_RST_N;
  logic            CMP_MODE;
  logic [DW*N-1:0] CMP_DIN;
  logic [DW-1:0]   CMP_DOUT;
  logic            CMP_DONE;
  logic            RES_VALID;
  logic            RES_READY;
  logic [DW-1:0]   RES_DATA;
  logic            RES_MODE;
  logic            TIMEOUT_ERR;

  always #5 CLK = ~CLK;

  sort_frame_loader #(
    .DATA_WIDTH     (DW),
    .NUM_INPUTS     (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .MODE_IN     (MODE_IN),
    .CMP_RST_N   (CMP_RST_N),
    .CMP_MODE    (CMP_MODE),
    .CMP_DIN     (CMP_DIN),
    .CMP_DOUT    (CMP_DOUT),
    .CMP_DONE    (CMP_DONE),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .RES_DATA    (RES_DATA),
    .RES_MODE    (RES_MODE),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  // Behavioural comparator: loads while in reset, sorts on the first edge out of
  // reset and pulses SORT_DONE once. stub_dead suppresses SORT_DONE entirely.
  logic [DW-1:0] cmp_dout  = '0;
  logic          cmp_done  = 1'b0;
  logic          cmp_fired = 1'b0;
  logic          stub_dead = 1'b0;

  function automatic logic [DW-1:0] cmp_pick(input logic [DW*N-1:0] din, input logic mode);
    logic [DW-1:0] b;
    logic [DW-1:0] v;
    b = din[DW-1:0];
    for (int k = 1; k < N; k++) begin
      v = din[k*DW +: DW];
      if (mode ? (v > b) : (v < b)) b = v;
    end
    return b;
  endfunction

  always @(posedge CLK) begin
    if (CMP_RST_N !== 1'b1) begin
      cmp_done  <= 1'b0;
      cmp_fired <= 1'b0;
    end else if (!cmp_fired) begin
      cmp_fired <= 1'b1;
      cmp_done  <= !stub_dead;
      cmp_dout  <= cmp_pick(CMP_DIN, CMP_MODE);
    end else begin
      cmp_done <= 1'b0;
    end
  end

  assign CMP_DOUT = cmp_dout;
  assign CMP_DONE = cmp_done;

  // Result-ready control.
  logic rr_fix  = 1'b1;
  logic rr_rand = 1'b0;
  logic rr_bit  = 1'b1;
  assign RES_READY = rr_rand ? rr_bit : rr_fix;

  initial forever begin
    @(posedge CLK);
    #1;
    rr_bit = 1'($urandom_range(0, 1));
  end

  // Counters and scoreboard.
  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int to_pulses = 0;
  int to_cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          mode;
    int            acc;
  } exp_t;
  exp_t sb[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sort the frame and take an end.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] w [N], input logic mode);
    logic [DW-1:0] q[$];
    foreach (w[k]) q.push_back(w[k]);
    q.sort();
    return mode ? q[q.size()-1] : q[0];
  endfunction

  // Monitor: checks every HOLD cycle against the scoreboard head; pops on handshake.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge CLK);
      if (RES_VALID === 1'b1) begin
        if (!prev_v) chk("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          // Rise is three edges after the accepting edge E0, i.e. acc+4 in negedge cycle count.
          if (!prev_v) chk("latency", 64'(cyc), 64'(sb[0].acc + 4));
          chk("res_data", 64'(RES_DATA), 64'(sb[0].data));
          chk("res_mode", 64'(RES_MODE), 64'(sb[0].mode));
          chk("hold_in_ready", 64'(IN_READY), 64'd0);
          chk("hold_cmp_rst_n", 64'(CMP_RST_N), 64'd0);
          if (RES_READY === 1'b1 && RST_N === 1'b1) void'(sb.pop_front());
        end
      end
      if (TIMEOUT_ERR === 1'b1) begin
        to_pulses++;
        to_cyc = cyc;
      end
      prev_v = (RES_VALID === 1'b1);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vecs);
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [DW-1:0] w, input logic m, input int gap, output int acc);
    int n;
    logic hs;
    IN_VALID = 1'b0;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b1;
    IN_DATA  = w;
    MODE_IN  = m;
    n  = 0;
    hs = 1'b0;
    acc = 0;
    while (!hs && n < 60) begin
      @(negedge CLK);
      hs  = (IN_READY === 1'b1);
      acc = cyc;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!hs) begin
      vecs++;
      errs++;
      $display("FAIL in_handshake: got no IN_READY within 60 cycles expected a handshake");
    end
    IN_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] w [N], input logic m, input int maxgap,
                            input bit expect_res, output int acc);
    for (int k = 0; k < N; k++) begin
      send_word(w[k], m, $urandom_range(0, maxgap), acc);
    end
    if (expect_res) sb.push_back('{data: model(w, m), mode: m, acc: acc});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_res_valid();
    int n;
    n = 0;
    while (RES_VALID !== 1'b1 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("res_valid_seen", 64'(RES_VALID), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [DW-1:0] f [N];
    int acc;
    int d;

    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    MODE_IN  = 1'b0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_in_ready",    64'(IN_READY),    64'd0);
    chk("rst_cmp_rst_n",   64'(CMP_RST_N),   64'd0);
    chk("rst_cmp_mode",    64'(CMP_MODE),    64'd0);
    chk("rst_cmp_din",     64'(CMP_DIN),     64'd0);
    chk("rst_res_valid",   64'(RES_VALID),   64'd0);
    chk("rst_res_data",    64'(RES_DATA),    64'd0);
    chk("rst_res_mode",    64'(RES_MODE),    64'd0);
    chk("rst_timeout_err", 64'(TIMEOUT_ERR), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("in_ready_before_first_edge", 64'(IN_READY), 64'd0);
    @(negedge CLK);
    chk("in_ready_after_release", 64'(IN_READY), 64'd1);
    @(posedge CLK);
    #1;

    // Basic frames, back to back.
    f = '{16'd45, 16'd3, 16'd29, 16'd88};
    send_frame(f, 1'b0, 0, 1'b1, acc);
    send_frame(f, 1'b1, 0, 1'b1, acc);
    wait_drain("drain_basic");

    // Input gaps and a result held for 5 cycles.
    rr_fix = 1'b0;
    send_frame(f, 1'b0, 3, 1'b1, acc);
    wait_res_valid();
    repeat (5) begin
      @(posedge CLK);
      #1;
    end
    rr_fix = 1'b1;
    wait_drain("drain_hold");

    // Dead comparator: one timeout pulse TO RUN cycles in, then recovery.
    stub_dead = 1'b1;
    to_pulses = 0;
    f = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_frame(f, 1'b0, 0, 1'b0, acc);
    while (cyc < acc + 12) begin
      @(negedge CLK);
      if (cyc == acc + 9) chk("in_ready_after_timeout", 64'(IN_READY), 64'd1);
    end
    chk("timeout_pulses", 64'(to_pulses), 64'd1);
    // RUN starts at E1; TO RUN cycles end at E(1+TO), seen at negedge acc+2+TO.
    chk("timeout_cycle", 64'(to_cyc), 64'(acc + 2 + TO));
    @(posedge CLK);
    #1;
    stub_dead = 1'b0;
    f = '{16'd45, 16'd3, 16'd29, 16'd88};
    send_frame(f, 1'b1, 0, 1'b1, acc);
    wait_drain("drain_after_timeout");

    // Reset in the middle of a frame.
    send_word(16'd7, 1'b0, 0, acc);
    send_word(16'd9, 1'b0, 0, acc);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    f = '{16'd100, 16'd200, 16'd50, 16'd150};
    send_frame(f, 1'b0, 0, 1'b1, acc);
    wait_drain("drain_mid_reset");

    // Reset while a result is held.
    rr_fix = 1'b0;
    f = '{16'd45, 16'd3, 16'd29, 16'd88};
    send_frame(f, 1'b1, 0, 1'b1, acc);
    wait_res_valid();
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("hold_reset_res_valid", 64'(RES_VALID), 64'd0);
    chk("hold_reset_res_data",  64'(RES_DATA),  64'd0);
    chk("hold_reset_cmp_rst_n", 64'(CMP_RST_N), 64'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    rr_fix = 1'b1;
    f = '{16'd0, 16'hFFFF, 16'd0, 16'hFFFF};
    send_frame(f, 1'b0, 0, 1'b1, acc);
    wait_drain("drain_hold_reset");

    // Extremes.
    f = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send_frame(f, 1'b0, 0, 1'b1, acc);
    send_frame(f, 1'b1, 0, 1'b1, acc);
    f = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    send_frame(f, 1'b1, 0, 1'b1, acc);
    send_frame(f, 1'b0, 0, 1'b1, acc);
    wait_drain("drain_extremes");

    // Randomised frames with random gaps and random result backpressure.
    rr_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) begin
        d = $urandom_range(0, 7);
        f[k] = (d == 0) ? 16'h0000 : (d == 1) ? 16'hFFFF : 16'($urandom);
      end
      send_frame(f, 1'($urandom_range(0, 1)), 3, 1'b1, acc);
    end
    rr_rand = 1'b0;
    wait_drain("drain_random");

    repeat (5) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
